// File: rtl/wave_stim_gen.sv
// wave_stim_gen: multi-channel waveform stimulus source.
//   NUM_CH independent WIDTH-bit channels. Each channel is selected at run time as an
//   up-counter, a down-counter, an LFSR random source or hold. A start/stop FSM with a
//   post-start hold-off sequences the channels. The LFSRs are seeded, so the output is
//   deterministic from reset.
// Ports:
//   clk      - clock, all logic on posedge
//   reset    - synchronous, active-low
//   start    - IDLE -> HOLDOFF/RUN request, ignored while busy
//   stop     - any state -> IDLE, has priority over start
//   mode     - per-channel mode, ch c = mode[2c+1:2c]: 0 up, 1 down, 2 random, 3 hold/4-state
//   step     - increment/decrement magnitude shared by all channels
//   ch_data  - channel values, ch c = ch_data[c*WIDTH +: WIDTH]
//   ch_wrap  - one-cycle carry (up) / borrow (down) pulse per channel
//   valid    - ch_data was updated this cycle
//   busy     - FSM is in HOLDOFF or RUN
// Build option:
//   WAVE_STIM_FOUR_STATE_EN - when defined, mode 3 drives 0/1/x/z per bit from LFSR bit pairs;
//                             when undefined, mode 3 holds the channel value.
module wave_stim_gen #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned HOLDOFF   = 16,
    parameter logic [31:0] LFSR_SEED = 32'hACE12468
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic [2*NUM_CH-1:0]       mode,
    input  logic [WIDTH-1:0]          step,
    output logic [NUM_CH*WIDTH-1:0]   ch_data,
    output logic [NUM_CH-1:0]         ch_wrap,
    output logic                      valid,
    output logic                      busy
);

    localparam int unsigned CNT_W     = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int unsigned HOLD_LAST = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     hold_cnt;
    logic [CNT_W-1:0]     hold_cnt_nxt;

    logic [31:0]          lfsr     [NUM_CH];
    logic [31:0]          lfsr_nxt [NUM_CH];
    logic [NUM_CH*WIDTH-1:0] data_nxt;
    logic [NUM_CH-1:0]    wrap_nxt;

    logic                 update;
    logic                 launch;
    logic [WIDTH:0]       sum_w;
    logic [31:0]          adv_w;
    logic [WIDTH-1:0]     cur_w;

    // Per-channel seed; an all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [31:0] seed_of(input int c);
        logic [31:0] s;
        s = LFSR_SEED ^ 32'(c + 1);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    // One Galois step, right-shifting form.
    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_TAPS : 32'h0);
    endfunction

`ifdef WAVE_STIM_FOUR_STATE_EN
    // Bit i of the result is chosen by LFSR bit pair {2i+1,2i} (mod 32): 00->0 01->1 10->x 11->z.
    function automatic logic [WIDTH-1:0] four_state(input logic [31:0] l);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case ({l[(2*i+1)%32], l[(2*i)%32]})
                2'b00:   r[i] = 1'b0;
                2'b01:   r[i] = 1'b1;
                2'b10:   r[i] = 1'bx;
                default: r[i] = 1'bz;
            endcase
        end
        return r;
    endfunction
`endif

    // Update edge: RUN and not being stopped. Launch edge: leaving IDLE on start.
    assign update = (state == ST_RUN) && !stop;
    assign launch = (state == ST_IDLE) && start && !stop;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Next-state logic; stop overrides every transition.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt    = (HOLDOFF == 0) ? ST_RUN : ST_HOLDOFF;
                    hold_cnt_nxt = '0;
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt == CNT_W'(HOLD_LAST)) begin
                    state_nxt    = ST_RUN;
                    hold_cnt_nxt = '0;
                end else begin
                    hold_cnt_nxt = hold_cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt    = ST_IDLE;
                hold_cnt_nxt = '0;
            end
        endcase
        if (stop) begin
            state_nxt    = ST_IDLE;
            hold_cnt_nxt = '0;
        end
    end

    // Channel datapath: every LFSR advances on an update edge, whatever its channel mode.
    always_comb begin
        data_nxt = ch_data;
        wrap_nxt = '0;
        sum_w    = '0;
        adv_w    = '0;
        cur_w    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            lfsr_nxt[c] = lfsr[c];
        end
        if (launch) begin
            data_nxt = '0;
        end
        if (update) begin
            for (int c = 0; c < NUM_CH; c++) begin
                adv_w       = lfsr_step(lfsr[c]);
                lfsr_nxt[c] = adv_w;
                cur_w       = ch_data[c*WIDTH +: WIDTH];
                case (mode[2*c +: 2])
                    2'd0: begin
                        sum_w                        = {1'b0, cur_w} + {1'b0, step};
                        data_nxt[c*WIDTH +: WIDTH]   = sum_w[WIDTH-1:0];
                        wrap_nxt[c]                  = sum_w[WIDTH];
                    end
                    2'd1: begin
                        data_nxt[c*WIDTH +: WIDTH]   = cur_w - step;
                        wrap_nxt[c]                  = (step > cur_w);
                    end
                    2'd2: begin
                        data_nxt[c*WIDTH +: WIDTH]   = adv_w[WIDTH-1:0];
                    end
                    default: begin
`ifdef WAVE_STIM_FOUR_STATE_EN
                        data_nxt[c*WIDTH +: WIDTH]   = four_state(adv_w);
`else
                        data_nxt[c*WIDTH +: WIDTH]   = cur_w;
`endif
                    end
                endcase
            end
        end
    end

    // Output and LFSR registers; busy follows the next state so it rises with the launch edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ch_data <= '0;
            ch_wrap <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                lfsr[c] <= seed_of(c);
            end
        end else begin
            ch_data <= data_nxt;
            ch_wrap <= wrap_nxt;
            valid   <= update;
            busy    <= (state_nxt != ST_IDLE);
            for (int c = 0; c < NUM_CH; c++) begin
                lfsr[c] <= lfsr_nxt[c];
            end
        end
    end

endmodule

// File: tb/tb_wave_stim_gen.sv
// Bench for wave_stim_gen: directed stimulus, a behavioural reference model checked every
// cycle, and hand-computed literal expectations for the key values.
module tb_wave_stim_gen;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned HOLDOFF = 4;
    localparam logic [31:0] SEED    = 32'hACE12468;
    localparam logic [31:0] TAPS    = 32'h80200003;
    localparam longint      MOD     = longint'(1) << WIDTH;

    logic                    clk;
    logic                    reset;
    logic                    start;
    logic                    stop;
    logic [2*NUM_CH-1:0]     mode;
    logic [WIDTH-1:0]        step;
    logic [NUM_CH*WIDTH-1:0] ch_data;
    logic [NUM_CH-1:0]       ch_wrap;
    logic                    valid;
    logic                    busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    wave_stim_gen #(
        .NUM_CH   (NUM_CH),
        .WIDTH    (WIDTH),
        .HOLDOFF  (HOLDOFF),
        .LFSR_SEED(SEED)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .step    (step),
        .ch_data (ch_data),
        .ch_wrap (ch_wrap),
        .valid   (valid),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase plus a hold-off countdown, channel values as plain numbers.
    typedef enum {M_IDLE, M_WAIT, M_RUN} phase_e;
    phase_e            m_phase = M_IDLE;
    int                m_left  = 0;
    logic [WIDTH-1:0]  m_d [NUM_CH];
    logic [31:0]       m_l [NUM_CH];
    logic [NUM_CH-1:0] m_wrap  = '0;
    logic              m_valid = 1'b0;
    logic              m_busy  = 1'b0;

    function automatic logic [31:0] m_seed(input int c);
        logic [31:0] s;
        s = SEED ^ 32'(c + 1);
        if (s == 32'h0) s = 32'h1;
        return s;
    endfunction

    function automatic logic [31:0] m_adv(input logic [31:0] l);
        logic [31:0] n;
        n = l >> 1;
        if (l[0]) n = n ^ TAPS;
        return n;
    endfunction

    always @(posedge clk) begin
        bit     running;
        longint v;
        logic [1:0] pr;
        running = (m_phase == M_RUN) && !stop;
        if (!reset) begin
            m_phase = M_IDLE;
            m_left  = 0;
            m_wrap  = '0;
            m_valid = 1'b0;
            m_busy  = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_d[c] = '0;
                m_l[c] = m_seed(c);
            end
        end else begin
            m_valid = running;
            m_wrap  = '0;
            if (running) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    m_l[c] = m_adv(m_l[c]);
                    case (mode[2*c +: 2])
                        2'd0: begin
                            v         = longint'(m_d[c]) + longint'(step);
                            m_wrap[c] = (v >= MOD);
                            m_d[c]    = WIDTH'(v % MOD);
                        end
                        2'd1: begin
                            m_wrap[c] = (step > m_d[c]);
                            v         = (longint'(m_d[c]) - longint'(step) + MOD) % MOD;
                            m_d[c]    = WIDTH'(v);
                        end
                        2'd2: m_d[c] = m_l[c][WIDTH-1:0];
                        default: begin
`ifdef WAVE_STIM_FOUR_STATE_EN
                            for (int i = 0; i < WIDTH; i++) begin
                                pr = {m_l[c][(2*i+1)%32], m_l[c][(2*i)%32]};
                                m_d[c][i] = (pr == 2'd0) ? 1'b0 : (pr == 2'd1) ? 1'b1 :
                                            (pr == 2'd2) ? 1'bx : 1'bz;
                            end
`endif
                        end
                    endcase
                end
            end
            if (stop) begin
                m_phase = M_IDLE;
            end else if (m_phase == M_IDLE && start) begin
                for (int c = 0; c < NUM_CH; c++) m_d[c] = '0;
                if (HOLDOFF == 0) begin
                    m_phase = M_RUN;
                end else begin
                    m_phase = M_WAIT;
                    m_left  = HOLDOFF;
                end
            end else if (m_phase == M_WAIT) begin
                m_left = m_left - 1;
                if (m_left == 0) m_phase = M_RUN;
            end
            m_busy = (m_phase != M_IDLE);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [NUM_CH*WIDTH-1:0] m_flat;
        if (chk_en) begin
            for (int c = 0; c < NUM_CH; c++) m_flat[c*WIDTH +: WIDTH] = m_d[c];
            checks++;
            if (ch_data !== m_flat || ch_wrap !== m_wrap || valid !== m_valid || busy !== m_busy) begin
                errors++;
                $display("FAIL model_cmp t=%0t ch_data act=%h exp=%h ch_wrap act=%b exp=%b valid act=%b exp=%b busy act=%b exp=%b",
                         $time, ch_data, m_flat, ch_wrap, m_wrap, valid, m_valid, busy, m_busy);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic launch_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (HOLDOFF) tick();
        tick();
    endtask

`ifdef WAVE_STIM_FOUR_STATE_EN
    int seen_x = 0;
    int seen_z = 0;
`endif

    initial begin
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        mode  = '0;
        step  = WIDTH'(1);
        tick();
        chk_en = 1;
        tick();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_data",  32'(ch_data), 32'd0);
        reset = 1'b1;
        tick();

        // ch0 up, ch1 down, ch2 random, ch3 hold; hold-off latency and ignored second start.
        mode  = 8'b11_10_01_00;
        step  = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ho_busy",  32'(busy),  32'd1);
        chk("ho_valid", 32'(valid), 32'd0);
        for (int i = 0; i < HOLDOFF; i++) begin
            start = (i == 1);
            tick();
            chk("ho_wait_valid", 32'(valid), 32'd0);
            chk("ho_wait_busy",  32'(busy),  32'd1);
        end
        start = 1'b0;
        tick();
        chk("first_valid",   32'(valid), 32'd1);
        chk("up_first",      32'(ch_data[7:0]),   32'h01);
        chk("dn_first",      32'(ch_data[15:8]),  32'hFF);
        chk("dn_first_wrap", 32'(ch_wrap[1]),     32'd1);
        chk("rnd_ch2_first", 32'(ch_data[23:16]), 32'h36);
        chk("hold_ch3",      32'(ch_data[31:24]), 32'h00);

        // Up-counter wrap at the 256th update.
        repeat (254) tick();
        chk("up_ff",        32'(ch_data[7:0]), 32'hFF);
        chk("up_ff_wrap",   32'(ch_wrap[0]),   32'd0);
        tick();
        chk("up_wrap_data", 32'(ch_data[7:0]), 32'h00);
        chk("up_wrap_pulse",32'(ch_wrap[0]),   32'd1);
        tick();
        chk("up_after",     32'(ch_data[7:0]), 32'h01);
        chk("up_after_wrap",32'(ch_wrap[0]),   32'd0);

        // Stop in RUN: value held, valid drops.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_valid", 32'(valid), 32'd0);
        chk("stop_busy",  32'(busy),  32'd0);
        chk("stop_hold",  32'(ch_data[7:0]), 32'h01);
        tick();

        // start and stop together in IDLE: stays IDLE.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_busy", 32'(busy), 32'd0);
        tick();
        chk("ss_busy2",  32'(busy),  32'd0);
        chk("ss_valid2", 32'(valid), 32'd0);

        // Down-counter step 3, then mode/step change mid-run.
        mode = 8'h55;
        step = 8'd3;
        launch_run();
        chk("dn3_a",      32'(ch_data[7:0]), 32'hFD);
        chk("dn3_a_wrap", 32'(ch_wrap[0]),   32'd1);
        tick();
        chk("dn3_b",      32'(ch_data[7:0]), 32'hFA);
        chk("dn3_b_wrap", 32'(ch_wrap[0]),   32'd0);
        tick();
        chk("dn3_c",      32'(ch_data[7:0]), 32'hF7);
        mode = 8'h54;
        step = 8'd5;
        tick();
        chk("mode_chg",   32'(ch_data[7:0]), 32'hFC);
        step = 8'd0;
        tick();
        chk("step0_hold", 32'(ch_data[7:0]), 32'hFC);
        chk("step0_wrap", 32'(ch_wrap),      32'd0);

        // Reset for two cycles mid-RUN.
        reset = 1'b0;
        tick();
        tick();
        chk("mid_rst_data",  32'(ch_data), 32'd0);
        chk("mid_rst_valid", 32'(valid),   32'd0);
        chk("mid_rst_busy",  32'(busy),    32'd0);
        chk("mid_rst_wrap",  32'(ch_wrap), 32'd0);
        reset = 1'b1;
        tick();

        // Random channels: distinct per channel, reproducible after reset.
        mode = 8'h0A;
        step = 8'd1;
        launch_run();
        chk("rnd_ch0", 32'(ch_data[7:0]),  32'h37);
        chk("rnd_ch1", 32'(ch_data[15:8]), 32'h35);
        repeat (10) tick();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        launch_run();
        chk("rnd_ch0_rerun", 32'(ch_data[7:0]),  32'h37);
        chk("rnd_ch1_rerun", 32'(ch_data[15:8]), 32'h35);
        repeat (10) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();

`ifdef WAVE_STIM_FOUR_STATE_EN
        reset = 1'b0;
        tick();
        reset = 1'b1;
        mode  = '1;
        launch_run();
        for (int n = 0; n < 256; n++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (ch_data[i] === 1'bx) seen_x++;
                if (ch_data[i] === 1'bz) seen_z++;
            end
            tick();
        end
        chk("fs_x_seen", 32'(seen_x > 0), 32'd1);
        chk("fs_z_seen", 32'(seen_z > 0), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
`endif

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
